// File: rtl/wb_write_arbiter.sv
// Register-file write-port master: merges pipeline writebacks with queued long-latency results.
// Optional starvation guard enabled by defining WB_STARVE_GUARD_EN.
module wb_write_arbiter #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pipe_we,
  input  logic [4:0]                 pipe_rw,
  input  logic [WIDTH-1:0]           pipe_wd,
  output logic                       pipe_stall,
  input  logic                       lu_valid,
  output logic                       lu_ready,
  input  logic [4:0]                 lu_rw,
  input  logic [WIDTH-1:0]           lu_wd,
  output logic                       we,
  output logic [4:0]                 rw,
  output logic [WIDTH-1:0]           wd,
  output logic                       pending,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [4:0]       mem_rw [DEPTH];
  logic [WIDTH-1:0] mem_wd [DEPTH];

  logic [PW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             we_q;
  logic [4:0]       rw_q;
  logic [WIDTH-1:0] wd_q;

  logic push, pop, pipe_win, fire;

  assign pending    = (count_q != '0);
  assign count      = count_q;
  assign lu_ready   = !reset && (count_q != CW'(DEPTH));
  assign pipe_stall = fire && !reset;
  assign we         = we_q;
  assign rw         = rw_q;
  assign wd         = wd_q;

`ifdef WB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_q, starve_d;

  assign fire = (starve_q == SW'(STARVE_LIMIT));

  // Counts consecutive cycles the queue was blocked by the pipeline; clears on firing.
  always_comb begin
    starve_d = '0;
    if (!fire && pipe_we && pending)
      starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) starve_q <= '0;
    else       starve_q <= starve_d;
  end
`else
  logic unused_limit;
  assign unused_limit = ^STARVE_LIMIT;
  assign fire         = 1'b0;
`endif

  always_comb begin
    push     = lu_valid && lu_ready;
    pipe_win = pipe_we && !fire;
    pop      = pending && !pipe_win;
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  // Queue storage carries no reset; occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_rw[wptr_q] <= lu_rw;
      mem_wd[wptr_q] <= lu_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      rw_q    <= '0;
      wd_q    <= '0;
    end else begin
      count_q <= count_d;
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      we_q <= pipe_win || pop;
      if (pipe_win) begin
        rw_q <= pipe_rw;
        wd_q <= pipe_wd;
      end else if (pop) begin
        rw_q <= mem_rw[rptr_q];
        wd_q <= mem_wd[rptr_q];
      end
    end
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter; guard checks follow WB_STARVE_GUARD_EN.
module tb_wb_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_we;
  logic [4:0]  pipe_rw;
  logic [31:0] pipe_wd;
  logic        pipe_stall;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_rw;
  logic [31:0] lu_wd;
  logic        we;
  logic [4:0]  rw;
  logic [31:0] wd;
  logic        pending;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  wb_write_arbiter #(.WIDTH(32), .DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .reset(reset),
    .pipe_we(pipe_we), .pipe_rw(pipe_rw), .pipe_wd(pipe_wd), .pipe_stall(pipe_stall),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rw(lu_rw), .lu_wd(lu_wd),
    .we(we), .rw(rw), .wd(wd), .pending(pending), .count(count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkPort(input string tag, input logic e_we, input logic [4:0] e_rw,
                           input logic [31:0] e_wd);
    checkOutput({tag, ".we"}, {31'b0, we}, {31'b0, e_we});
    if (e_we) begin
      checkOutput({tag, ".rw"}, {27'b0, rw}, {27'b0, e_rw});
      checkOutput({tag, ".wd"}, wd, e_wd);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1; pipe_we = 1'b0; pipe_rw = '0; pipe_wd = '0;
    lu_valid = 1'b0; lu_rw = '0; lu_wd = '0;
    tick();
    tick();
    #1;
    checkOutput("reset.lu_ready", {31'b0, lu_ready}, 32'd0);
    checkOutput("reset.pipe_stall", {31'b0, pipe_stall}, 32'd0);
    reset = 1'b0;
    #1;
    checkPort("post_reset", 1'b0, 5'd0, 32'd0);
    checkOutput("post_reset.rw", {27'b0, rw}, 32'd0);
    checkOutput("post_reset.wd", wd, 32'd0);
    checkOutput("post_reset.count", {29'b0, count}, 32'd0);
    checkOutput("post_reset.lu_ready", {31'b0, lu_ready}, 32'd1);

    // Single pipeline write
    pipe_we = 1'b1; pipe_rw = 5'd3; pipe_wd = 32'hFFFF0003;
    tick();
    checkPort("pipe_write", 1'b1, 5'd3, 32'hFFFF0003);
    pipe_we = 1'b0;
    tick();
    checkPort("idle", 1'b0, 5'd0, 32'd0);

    // Pipeline beats a same-cycle push; queued entry retires next
    pipe_we = 1'b1; pipe_rw = 5'd1; pipe_wd = 32'hFFFF0001;
    lu_valid = 1'b1; lu_rw = 5'd2; lu_wd = 32'hFFFF0002;
    tick();
    checkPort("prio.first", 1'b1, 5'd1, 32'hFFFF0001);
    checkOutput("prio.pending", {31'b0, pending}, 32'd1);
    pipe_we = 1'b0; lu_valid = 1'b0;
    tick();
    checkPort("prio.second", 1'b1, 5'd2, 32'hFFFF0002);
    checkOutput("prio.pending_after", {31'b0, pending}, 32'd0);
    tick();
    checkPort("prio.idle", 1'b0, 5'd0, 32'd0);

    // Fill to full under a busy pipeline, then drain in order
    pipe_we = 1'b1; pipe_rw = 5'd8; pipe_wd = 32'h11;
    for (int i = 0; i < 4; i++) begin
      lu_valid = 1'b1; lu_rw = 5'(4 + i); lu_wd = 32'hA0 + 32'(i);
      tick();
      checkPort("fill.pipe", 1'b1, 5'd8, 32'h11);
      checkOutput("fill.count", {29'b0, count}, 32'(i + 1));
    end
    lu_rw = 5'd9; lu_wd = 32'hBAD;
    #1;
    checkOutput("full.lu_ready", {31'b0, lu_ready}, 32'd0);
    tick();
    checkOutput("full.count", {29'b0, count}, 32'd4);
    pipe_we = 1'b0; lu_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkPort("drain", 1'b1, 5'(4 + i), 32'hA0 + 32'(i));
      checkOutput("drain.count", {29'b0, count}, 32'(3 - i));
    end

    // Simultaneous push and pop at occupancy 2
    pipe_we = 1'b1;
    lu_valid = 1'b1; lu_rw = 5'd10; lu_wd = 32'hB0;
    tick();
    lu_rw = 5'd11; lu_wd = 32'hB1;
    tick();
    checkOutput("pp.count_before", {29'b0, count}, 32'd2);
    pipe_we = 1'b0; lu_rw = 5'd12; lu_wd = 32'hB2;
    tick();
    checkPort("pp.pop", 1'b1, 5'd10, 32'hB0);
    checkOutput("pp.count_after", {29'b0, count}, 32'd2);
    lu_valid = 1'b0;
    tick();
    checkPort("pp.r11", 1'b1, 5'd11, 32'hB1);
    tick();
    checkPort("pp.r12", 1'b1, 5'd12, 32'hB2);
    checkOutput("pp.count_empty", {29'b0, count}, 32'd0);

    // Starvation: continuous pipeline with one queued entry
    pipe_we = 1'b1; pipe_rw = 5'd8; pipe_wd = 32'h11;
    lu_valid = 1'b1; lu_rw = 5'd13; lu_wd = 32'hC0;
    tick();
    lu_valid = 1'b0;
`ifdef WB_STARVE_GUARD_EN
    for (int k = 1; k <= 9; k++) begin
      #1;
      checkOutput("guard.stall", {31'b0, pipe_stall}, (k == 9) ? 32'd1 : 32'd0);
      tick();
      if (k < 9) checkPort("guard.pipe", 1'b1, 5'd8, 32'h11);
      else       checkPort("guard.retire", 1'b1, 5'd13, 32'hC0);
    end
    checkOutput("guard.count", {29'b0, count}, 32'd0);
`else
    for (int k = 1; k <= 12; k++) begin
      #1;
      checkOutput("noguard.stall", {31'b0, pipe_stall}, 32'd0);
      tick();
      checkPort("noguard.pipe", 1'b1, 5'd8, 32'h11);
      checkOutput("noguard.count", {29'b0, count}, 32'd1);
    end
    pipe_we = 1'b0;
    tick();
    checkPort("noguard.retire", 1'b1, 5'd13, 32'hC0);
`endif

    // Mid-operation reset with three queued entries
    pipe_we = 1'b1;
    for (int i = 0; i < 3; i++) begin
      lu_valid = 1'b1; lu_rw = 5'(14 + i); lu_wd = 32'hD0 + 32'(i);
      tick();
    end
    checkOutput("midrst.count_before", {29'b0, count}, 32'd3);
    reset = 1'b1;
    #1;
    checkOutput("midrst.lu_ready", {31'b0, lu_ready}, 32'd0);
    checkOutput("midrst.pipe_stall", {31'b0, pipe_stall}, 32'd0);
    tick();
    checkOutput("midrst.count", {29'b0, count}, 32'd0);
    checkOutput("midrst.we", {31'b0, we}, 32'd0);
    reset = 1'b0; pipe_we = 1'b0; lu_valid = 1'b0;
    tick();
    checkOutput("midrst.no_stale", {31'b0, we}, 32'd0);
    checkOutput("midrst.pending", {31'b0, pending}, 32'd0);
    tick();
    checkOutput("midrst.no_stale2", {31'b0, we}, 32'd0);

    pipe_we = 1'b1; pipe_rw = 5'd5; pipe_wd = 32'h55;
    tick();
    checkPort("recover", 1'b1, 5'd5, 32'h55);
    pipe_we = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_write_arbiter.md
# wb_write_arbiter

Write-side master for the ID-stage `registers` file: merges single-cycle pipeline writebacks with results from the long-latency RSA unit (modexp) into the register file's single write port (`we`, `rw`, `wd`). Long-latency results are queued in a small FIFO and retired whenever the pipeline does not need the port. An optional starvation guard forces a FIFO retire and stalls the pipeline for that cycle.

## Interface
- `WIDTH`, 32, data width; matches the register file width.
- `DEPTH`, 4, number of long-latency FIFO entries; must be a power of two, at least 2.
- `STARVE_LIMIT`, 8, consecutive blocked cycles before the guard fires; used only with the guard macro.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `pipe_we`  in  1  pipeline writeback request this cycle.
- `pipe_rw`  in  5  pipeline destination register.
- `pipe_wd`  in  WIDTH  pipeline write data.
- `pipe_stall`  out  1  pipeline write not accepted this cycle; the pipeline holds and re-presents it.
- `lu_valid`  in  1  long-latency result offered.
- `lu_ready`  out  1  FIFO can accept a result.
- `lu_rw`  in  5  long-latency destination register.
- `lu_wd`  in  WIDTH  long-latency result data.
- `we`  out  1  register file write enable (registered).
- `rw`  out  5  register file write address (registered).
- `wd`  out  WIDTH  register file write data (registered).
- `pending`  out  1  FIFO non-empty.
- `count`  out  $clog2(DEPTH+1)  FIFO occupancy.

## Operation
**Push**
- A result is pushed when `lu_valid && lu_ready`.
- `lu_ready = !reset && (count != DEPTH)`. This is combinational from the registered `count`.

**Port selection (per cycle)**
- If `pipe_we` is high and the guard is not firing, the pipeline write wins.
- Otherwise, if the FIFO is non-empty, the FIFO head is popped and written.
- Otherwise, `we` is 0 next cycle.

**FIFO behaviour**
- Circular buffer with read/write pointers that wrap modulo DEPTH.
- Push and pop in the same cycle are both allowed. `count` is unchanged, and this works at any occupancy below full.
- When the FIFO is full, `lu_ready` is 0, so no push can occur; a pop in that cycle frees one slot for the next cycle.
- Retire order equals push order.

**Register 0 and hazards**
- Writes to register 0 are passed through unfiltered; the register file owns that policy.
- Write-after-write ordering between a queued result and a newer pipeline write to the same register is not resolved here. Issue logic must not issue a consumer or overwriter of a register while `pending` shows an outstanding write to it.

**Reset**
- `we`=0, `rw`=0, `wd`=0.
- `count`=0, both pointers 0.
- Starvation counter 0.
- `pipe_stall`=0, `lu_ready`=0 while `reset` is high.
- Reset asserted mid-operation discards all queued entries. No write is issued in the cycle after reset.

## Timing
- **Latency:** exactly 1 cycle from the accepted request cycle to `we`/`rw`/`wd` on the port. The register file commits on the following edge.
- **Pipeline path:** `pipe_we` in cycle N gives `we`=1 with `pipe_rw`/`pipe_wd` in cycle N+1, unless `pipe_stall` is high in N.
- **FIFO path:** minimum push-to-port latency is 2 cycles (push at edge N, pop in cycle N+1, on the port in N+2).
- **Full-rate pipeline:** with continuous `pipe_we`, the FIFO drains only through the guard.
- **Handshake:** `lu_rw`/`lu_wd` are sampled only on the push edge. The producer may drop `lu_valid` at any time before acceptance.

## Configuration
Macro: `WB_STARVE_GUARD_EN`.

**Defined:**
- A counter increments each cycle that `pipe_we && pending` holds, and clears otherwise.
- When the counter equals STARVE_LIMIT:
  - `pipe_stall`=1 (combinational);
  - the FIFO head is written instead of the pipeline request;
  - the counter clears.

**Not defined:**
- `pipe_stall` is tied to 0 and the counter is removed.
- The pipeline always wins, and FIFO entries wait until a cycle with `pipe_we`=0.

## Test plan
- **Reset state:** hold `reset` 2 cycles, then release → `we`=0, `count`=0, `lu_ready`=1 in the first post-reset cycle.
- **Pipeline write:** `pipe_we`=1, `pipe_rw`=3, `pipe_wd`=32'hFFFF0003 → next cycle `we`=1, `rw`=3, `wd`=32'hFFFF0003. A registers read of r3 afterwards returns 32'hFFFF0003.
- **Priority:** `pipe_we`=1 (r1, 32'hFFFF0001) and, in the same cycle, a push of (r2, 32'hFFFF0002) → r1 is written first. The next cycle, with `pipe_we`=0, r2 is written. `pending` falls after the pop.
- **Fill and order:** hold `pipe_we`=1 and push 4 results (r4..r7, 32'hA0..32'hA3) → `count`=4, `lu_ready`=0, and a 5th offer is not accepted. Then drop `pipe_we` → r4, r5, r6, r7 are written in order on consecutive cycles.
- **Simultaneous push/pop:** with `count`=2, push and pop in one cycle → `count` stays 2. Pointer wrap is exercised by 9 or more total pushes with data intact.
- **Guard** (macro defined, STARVE_LIMIT=8): continuous `pipe_we` with one queued entry → `pipe_stall`=1 in exactly the 9th cycle and the FIFO entry is written.
- **Guard** (macro not defined): same stimulus → `pipe_stall` is never asserted and the entry stays queued.
- **Mid-operation reset:** reset with `count`=3 → `count`=0 and no stale write appears.
